// File: rtl/frame_assembler.sv
// Serial word-to-frame assembler: command, address and value words
// are packed into one parallel frame with a held valid level.
module frame_assembler #(
    parameter int WORD_WIDTH     = 8,
    parameter int VALUE_WORDS    = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int DV_HOLD_CYCLES = 2
) (
    input  logic                                      clk,
    input  logic                                      i_reset,
    input  logic [WORD_WIDTH-1:0]                     i_byte,
    input  logic                                      i_byte_dv,
    output logic [(VALUE_WORDS+2)*WORD_WIDTH-1:0]     o_data,
    output logic                                      o_dv,
    output logic                                      o_timeout,
    output logic                                      o_overrun,
    output logic [7:0]                                o_frame_count
);

    localparam int FW  = VALUE_WORDS + 2;
    localparam int DW  = FW * WORD_WIDTH;
    localparam int WCW = $clog2(FW);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HCW = $clog2(DV_HOLD_CYCLES + 1);

    localparam logic [WCW-1:0] WC_LAST = WCW'(FW - 1);
    localparam logic [TCW-1:0] TC_LAST = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [HCW-1:0] HC_LAST = HCW'(DV_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_EMIT
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic [DW-1:0]   data_q,  data_d;
    logic [WCW-1:0]  wcnt_q,  wcnt_d;
    logic [TCW-1:0]  tcnt_q,  tcnt_d;
    logic [HCW-1:0]  hcnt_q,  hcnt_d;
    logic [7:0]      fcnt_q,  fcnt_d;
    logic            dv_q,    dv_d;
    logic            tout_q,  tout_d;
    logic            ovr_q,   ovr_d;
    logic [DW-1:0]   shift_in;

    assign shift_in = {shift_q[DW-WORD_WIDTH-1:0], i_byte};

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            data_q  <= '0;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
            hcnt_q  <= '0;
            fcnt_q  <= '0;
            dv_q    <= 1'b0;
            tout_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            wcnt_q  <= wcnt_d;
            tcnt_q  <= tcnt_d;
            hcnt_q  <= hcnt_d;
            fcnt_q  <= fcnt_d;
            dv_q    <= dv_d;
            tout_q  <= tout_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        data_d  = data_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;
        hcnt_d  = hcnt_q;
        fcnt_d  = fcnt_q;
        dv_d    = 1'b0;
        tout_d  = 1'b0;
        ovr_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                tcnt_d = '0;
                hcnt_d = '0;
                if (i_byte_dv) begin
                    shift_d = {{(DW-WORD_WIDTH){1'b0}}, i_byte};
                    wcnt_d  = WCW'(1);
                    state_d = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (i_byte_dv) begin
                    // An accepted word always wins over a due timeout.
                    shift_d = shift_in;
                    tcnt_d  = '0;
                    if (wcnt_q == WC_LAST) begin
                        data_d  = shift_in;
                        fcnt_d  = fcnt_q + 8'd1;
                        wcnt_d  = '0;
                        hcnt_d  = '0;
                        dv_d    = 1'b1;
                        state_d = S_EMIT;
                    end else begin
                        wcnt_d = wcnt_q + WCW'(1);
                    end
                end else if (tcnt_q == TC_LAST) begin
                    shift_d = '0;
                    wcnt_d  = '0;
                    tcnt_d  = '0;
                    tout_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TCW'(1);
                end
            end

            S_EMIT: begin
                tcnt_d = '0;
                ovr_d  = i_byte_dv;
                if (hcnt_q == HC_LAST) begin
                    hcnt_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    hcnt_d = hcnt_q + HCW'(1);
                    dv_d   = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_data        = data_q;
    assign o_dv          = dv_q;
    assign o_timeout     = tout_q;
    assign o_overrun     = ovr_q;
    assign o_frame_count = fcnt_q;

endmodule

// File: tb/tb_frame_assembler.sv
// Scoreboard bench for frame_assembler: expected frames are queued at
// stimulus time and checked by a monitor on each o_dv rising edge.
module tb_frame_assembler;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [7:0]  i_byte;
    logic        i_byte_dv;
    logic [47:0] o_data;
    logic        o_dv;
    logic        o_timeout;
    logic        o_overrun;
    logic [7:0]  o_frame_count;

    frame_assembler #(
        .WORD_WIDTH    (8),
        .VALUE_WORDS   (4),
        .TIMEOUT_CYCLES(1000),
        .DV_HOLD_CYCLES(2)
    ) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_byte       (i_byte),
        .i_byte_dv    (i_byte_dv),
        .o_data       (o_data),
        .o_dv         (o_dv),
        .o_timeout    (o_timeout),
        .o_overrun    (o_overrun),
        .o_frame_count(o_frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] data;
        logic [7:0]  fc;
        int          cyc;
    } exp_t;

    exp_t       expq[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         exp_tout = 0;
    int         exp_ovr  = 0;
    int         tout_seen = 0;
    int         ovr_seen  = 0;
    logic [7:0] exp_fc   = 8'd0;
    logic       mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: frame pops on o_dv rise, pulse widths, event counts.
    logic prev_dv = 1'b0, prev_to = 1'b0, prev_ov = 1'b0;
    int   dv_run = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_dv && !prev_dv) begin
                if (expq.size() == 0) begin
                    chk("unexpected_frame", {16'h0, o_data}, 64'h0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("frame_data", {16'h0, o_data}, {16'h0, e.data});
                    chk("frame_count", {56'h0, o_frame_count}, {56'h0, e.fc});
                    chk("frame_latency", 64'(cyc), 64'(e.cyc));
                end
            end
            if (o_dv) dv_run++;
            if (!o_dv && prev_dv) begin
                chk("dv_width", 64'(dv_run), 64'd2);
                dv_run = 0;
            end
            if (o_timeout) begin
                tout_seen++;
                if (prev_to) chk("timeout_width", 64'd2, 64'd1);
            end
            if (o_overrun) begin
                ovr_seen++;
                if (prev_ov) chk("overrun_width", 64'd2, 64'd1);
            end
            prev_dv = o_dv;
            prev_to = o_timeout;
            prev_ov = o_overrun;
        end
    end

    task automatic strobe(input logic [7:0] b);
        i_byte    = b;
        i_byte_dv = 1'b1;
        @(negedge clk);
        i_byte_dv = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                exp_t e;
                exp_fc = exp_fc + 8'd1;
                e.data = f;
                e.fc   = exp_fc;
                e.cyc  = cyc + 1;
                expq.push_back(e);
            end
            strobe(f[47-8*i -: 8]);
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        idle(3);
        i_reset = 1'b0;
        exp_fc  = 8'd0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_data"}, {16'h0, o_data}, 64'h0);
        chk({nm, "_flags"}, {61'h0, o_dv, o_timeout, o_overrun}, 64'h0);
        chk({nm, "_count"}, {56'h0, o_frame_count}, 64'h0);
    endtask

    initial begin
        i_reset   = 1'b1;
        i_byte    = 8'h00;
        i_byte_dv = 1'b0;
        @(negedge clk);
        do_reset();
        chk_zero("reset");
        mon_en = 1'b1;

        // Basic frame
        send_frame(48'h0105DEADBEEF);
        idle(3);
        chk("basic_count", {56'h0, o_frame_count}, 64'd1);
        chk("basic_dv_low", {63'h0, o_dv}, 64'd0);

        // Timeout on partial frame, then a clean frame
        do_reset();
        strobe(8'h01);
        strobe(8'h05);
        strobe(8'hDE);
        idle(999);
        chk("no_early_timeout", {63'h0, o_timeout}, 64'd0);
        idle(1);
        exp_tout++;
        chk("timeout_pulse", {63'h0, o_timeout}, 64'd1);
        chk("timeout_data", {16'h0, o_data}, 64'h0);
        idle(1);
        chk("timeout_one_cycle", {63'h0, o_timeout}, 64'd0);
        send_frame(48'h020700000011);
        idle(3);
        chk("after_timeout_count", {56'h0, o_frame_count}, 64'd1);

        // Overrun on first EMIT cycle
        send_frame(48'h112233445566);
        strobe(8'h55);
        exp_ovr++;
        chk("overrun_pulse", {63'h0, o_overrun}, 64'd1);
        idle(2);
        chk("overrun_data_held", {16'h0, o_data}, 64'h112233445566);
        send_frame(48'h0A0B0C0D0E0F);
        idle(3);

        // Reset mid-frame with simultaneous strobe; first post-reset strobe accepted
        strobe(8'h10);
        strobe(8'h20);
        strobe(8'h30);
        strobe(8'h40);
        i_reset   = 1'b1;
        i_byte    = 8'h77;
        i_byte_dv = 1'b1;
        @(negedge clk);
        i_reset   = 1'b0;
        i_byte_dv = 1'b0;
        exp_fc    = 8'd0;
        chk_zero("midreset");
        send_frame(48'hAA0100000002);
        idle(3);
        chk("midreset_count", {56'h0, o_frame_count}, 64'd1);

        // 257 frames wrap the count back to 1
        do_reset();
        for (int k = 0; k < 257; k++) begin
            logic [7:0] kb;
            kb = 8'(k);
            send_frame({kb, 8'h5A, ~kb, 8'h00, 8'h01, kb + 8'd3});
            idle(2);
        end
        chk("wrap_count", {56'h0, o_frame_count}, 64'd1);

        // Strobe exactly on the cycle a timeout would fire
        strobe(8'h33);
        strobe(8'h44);
        strobe(8'h01);
        idle(999);
        strobe(8'h02);
        chk("suppressed_timeout", {63'h0, o_timeout}, 64'd0);
        strobe(8'h03);
        exp_fc = exp_fc + 8'd1;
        begin
            exp_t e;
            e.data = 48'h334401020304;
            e.fc   = exp_fc;
            e.cyc  = cyc + 1;
            expq.push_back(e);
        end
        strobe(8'h04);
        idle(4);
        chk("late_strobe_count", {56'h0, o_frame_count}, 64'd2);

        chk("queue_drained", 64'(expq.size()), 64'd0);
        chk("timeout_events", 64'(tout_seen), 64'(exp_tout));
        chk("overrun_events", 64'(ovr_seen), 64'(exp_ovr));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
